// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM state encoding
//   ifid_sel_e    : IF/ID register next-value select
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
//   OP_*          : opcode constants seen on the opcode output
//   PC_STEP       : sequential PC increment
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StDrop
  } fetch_state_e;

  typedef enum logic [1:0] {
    IfidHold,
    IfidLoad,
    IfidBubble,
    IfidSkid
  } ifid_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Instructions are word aligned; the low two bits are always cleared.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   sel             : hold / load (in_pc, in_instr) / bubble / unload skid buffer
//   skid_wr         : capture in_pc/in_instr into the skid buffer
//   in_pc, in_instr : PC and word of the instruction returned this cycle
//   valid, pc, instr: registered IF/ID contents
module fetch_ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NopInstr = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ifid_sel_e   sel,
  input  logic        skid_wr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= 32'h0;
      instr_q      <= NopInstr;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NopInstr;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    case (sel)
      IfidLoad: begin
        valid_d = 1'b1;
        pc_d    = in_pc;
        instr_d = in_instr;
      end
      // A bubble keeps the last PC and also discards any buffered entry.
      IfidBubble: begin
        valid_d      = 1'b0;
        instr_d      = NopInstr;
        skid_valid_d = 1'b0;
      end
      IfidSkid: begin
        valid_d      = skid_valid_q;
        pc_d         = skid_pc_q;
        instr_d      = skid_instr_q;
        skid_valid_d = 1'b0;
      end
      default: ;
    endcase

    if (skid_wr) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = in_pc;
      skid_instr_d = in_instr;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding req/ack reads,
// and drives the IF/ID register consumed by decode/Control.
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   start_i               : begin fetching (sampled in idle only)
//   imem_req_o/addr_o     : instruction memory request and address
//   imem_ack_i/data_i     : memory completion and returned word
//   stall_i               : hold IF/ID and PC
//   flush_i, branch_target_i : redirect from ID
//   ifid_valid_o/pc_o/instr_o/op_o : IF/ID contents and opcode
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic [6:0]  ifid_op_o
);

  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  // Address of the abandoned request, kept on the bus while in StDrop.
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  target;
  logic [31:0]  pc_inc;
  ifid_sel_e    ifid_sel;
  logic         skid_wr;

  assign target = align_pc(branch_target_i);
  assign pc_inc = pc_q + PC_STEP;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      pc_q        <= align_pc(PC_RESET);
      drop_addr_q <= align_pc(PC_RESET);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // Priority: flush > stall > ack.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    ifid_sel    = IfidHold;
    skid_wr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          pc_d     = target;
          ifid_sel = IfidBubble;
        end else if (start_i) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (flush_i) begin
          pc_d     = target;
          ifid_sel = IfidBubble;
          if (!imem_ack_i) begin
            state_d     = StDrop;
            drop_addr_d = pc_q;
          end
        end else if (stall_i) begin
          if (imem_ack_i) begin
            skid_wr = 1'b1;
            pc_d    = pc_inc;
            state_d = StHold;
          end
        end else if (imem_ack_i) begin
          ifid_sel = IfidLoad;
          pc_d     = pc_inc;
        end else begin
          ifid_sel = IfidBubble;
        end
      end
      StHold: begin
        if (flush_i) begin
          pc_d     = target;
          ifid_sel = IfidBubble;
          state_d  = StReq;
        end else if (!stall_i) begin
          ifid_sel = IfidSkid;
          state_d  = StReq;
        end
      end
      StDrop: begin
        ifid_sel = IfidBubble;
        if (flush_i) begin
          pc_d = target;
        end
        // The stale access must complete before the redirected one is issued.
        if (imem_ack_i) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req_o  = (state_q == StReq) || (state_q == StDrop);
    imem_addr_o = (state_q == StDrop) ? drop_addr_q : pc_q;
  end

  fetch_ifid_reg #(
    .NopInstr(NOP_INSTR)
  ) u_ifid (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .sel     (ifid_sel),
    .skid_wr (skid_wr),
    .in_pc   (pc_q),
    .in_instr(imem_data_i),
    .valid   (ifid_valid_o),
    .pc      (ifid_pc_o),
    .instr   (ifid_instr_o)
  );

  assign ifid_op_o = ifid_instr_o[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XORV = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default reset PC, directed memory acks.
  logic        a_start = 0, a_stall = 0, a_flush = 0, a_ack_en = 0;
  logic [31:0] a_target = 0;
  logic        a_req, a_ack, a_valid;
  logic [31:0] a_addr, a_data, a_pc, a_instr;
  logic [6:0]  a_op;

  assign a_ack  = a_req & a_ack_en;
  assign a_data = a_addr ^ XORV;

  fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .start_i        (a_start),
    .imem_req_o     (a_req),
    .imem_addr_o    (a_addr),
    .imem_ack_i     (a_ack),
    .imem_data_i    (a_data),
    .stall_i        (a_stall),
    .flush_i        (a_flush),
    .branch_target_i(a_target),
    .ifid_valid_o   (a_valid),
    .ifid_pc_o      (a_pc),
    .ifid_instr_o   (a_instr),
    .ifid_op_o      (a_op)
  );

  // DUT B: reset PC near the top of the address space, zero-wait memory.
  logic        b_start = 0;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_data, b_pc, b_instr;
  logic [6:0]  b_op;

  assign b_data = b_addr ^ XORV;

  fetch_unit #(
    .PC_RESET(32'hFFFF_FFF8)
  ) dut_wrap (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .start_i        (b_start),
    .imem_req_o     (b_req),
    .imem_addr_o    (b_addr),
    .imem_ack_i     (b_req),
    .imem_data_i    (b_data),
    .stall_i        (1'b0),
    .flush_i        (1'b0),
    .branch_target_i(32'h0),
    .ifid_valid_o   (b_valid),
    .ifid_pc_o      (b_pc),
    .ifid_instr_o   (b_instr),
    .ifid_op_o      (b_op)
  );

  typedef struct {
    logic        start, stall, flush, ack;
    logic [31:0] tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc, einstr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic st, input logic sl, input logic fl, input logic ak,
                     input logic [31:0] tg, input logic rq, input logic [31:0] ad,
                     input logic vl, input logic [31:0] pc, input logic [31:0] ins);
    vec_t v;
    v.start = st; v.stall = sl; v.flush = fl; v.ack = ak; v.tgt = tg;
    v.ereq = rq; v.eaddr = ad; v.evalid = vl; v.epc = pc; v.einstr = ins;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] d(input logic [31:0] a);
    return a ^ XORV;
  endfunction

  initial begin
    // Fields: start stall flush ack target | req addr | valid pc instr (after the edge)
    add(1, 0, 0, 0, 0,    0, 32'h000, 0, 32'h000, NOP);        // start pulse
    add(0, 0, 0, 1, 0,    1, 32'h000, 1, 32'h000, d(32'h000)); // zero-wait stream
    add(0, 0, 0, 1, 0,    1, 32'h004, 1, 32'h004, d(32'h004));
    add(0, 0, 0, 1, 0,    1, 32'h008, 1, 32'h008, d(32'h008));
    add(0, 0, 0, 1, 0,    1, 32'h00C, 1, 32'h00C, d(32'h00C));
    add(0, 1, 0, 1, 0,    1, 32'h010, 1, 32'h00C, d(32'h00C)); // stall with ack -> hold
    add(0, 1, 0, 1, 0,    0, 32'h014, 1, 32'h00C, d(32'h00C));
    add(0, 1, 0, 1, 0,    0, 32'h014, 1, 32'h00C, d(32'h00C));
    add(0, 0, 0, 1, 0,    0, 32'h014, 1, 32'h010, d(32'h010)); // skid unload
    add(0, 0, 0, 1, 0,    1, 32'h014, 1, 32'h014, d(32'h014));
    add(0, 0, 0, 1, 0,    1, 32'h018, 1, 32'h018, d(32'h018));
    add(0, 0, 0, 1, 0,    1, 32'h01C, 1, 32'h01C, d(32'h01C));
    add(0, 0, 0, 0, 0,    1, 32'h020, 0, 32'h01C, NOP);        // pending, no ack
    add(0, 0, 1, 0, 32'h103, 1, 32'h020, 0, 32'h01C, NOP);     // flush -> drop
    add(0, 0, 0, 0, 0,    1, 32'h020, 0, 32'h01C, NOP);
    add(0, 0, 0, 1, 0,    1, 32'h020, 0, 32'h01C, NOP);        // stale ack discarded
    add(0, 0, 0, 1, 0,    1, 32'h100, 1, 32'h100, d(32'h100));
    add(0, 0, 0, 0, 0,    1, 32'h104, 0, 32'h100, NOP);        // 2-cycle latency
    add(0, 0, 0, 0, 0,    1, 32'h104, 0, 32'h100, NOP);
    add(0, 0, 0, 1, 0,    1, 32'h104, 1, 32'h104, d(32'h104));
    add(0, 0, 0, 0, 0,    1, 32'h108, 0, 32'h104, NOP);
    add(0, 0, 0, 0, 0,    1, 32'h108, 0, 32'h104, NOP);
    add(0, 0, 0, 1, 0,    1, 32'h108, 1, 32'h108, d(32'h108));
    add(0, 1, 1, 1, 32'h200, 1, 32'h10C, 0, 32'h108, NOP);     // flush beats stall
    add(0, 0, 0, 1, 0,    1, 32'h200, 1, 32'h200, d(32'h200));
    add(0, 1, 0, 0, 0,    1, 32'h204, 1, 32'h200, d(32'h200)); // stall without ack
    add(0, 0, 0, 1, 0,    1, 32'h204, 1, 32'h204, d(32'h204));
    add(0, 1, 0, 1, 0,    1, 32'h208, 1, 32'h204, d(32'h204)); // -> hold
    add(0, 1, 1, 1, 32'h301, 0, 32'h20C, 0, 32'h204, NOP);     // flush in hold
    add(0, 0, 0, 1, 0,    1, 32'h300, 1, 32'h300, d(32'h300));
    add(0, 0, 0, 0, 0,    1, 32'h304, 0, 32'h300, NOP);
    add(0, 0, 1, 0, 32'h400, 1, 32'h304, 0, 32'h300, NOP);     // -> drop
    add(0, 0, 1, 0, 32'h502, 1, 32'h304, 0, 32'h300, NOP);     // re-flush in drop
    add(0, 0, 0, 1, 0,    1, 32'h304, 0, 32'h300, NOP);
    add(0, 0, 0, 1, 0,    1, 32'h500, 1, 32'h500, d(32'h500));

    // Reset state, checked with reset still applied.
    @(posedge clk); #1;
    check("rst_req", {31'b0, a_req}, 32'h0);
    check("rst_addr", a_addr, 32'h0);
    check("rst_valid", {31'b0, a_valid}, 32'h0);
    check("rst_pc", a_pc, 32'h0);
    check("rst_instr", a_instr, NOP);
    check("rst_op", {25'b0, a_op}, 32'h13);
    check("rst_b_addr", b_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_start  = vecs[i].start;
      a_stall  = vecs[i].stall;
      a_flush  = vecs[i].flush;
      a_ack_en = vecs[i].ack;
      a_target = vecs[i].tgt;
      #1;
      check($sformatf("v%0d_req", i), {31'b0, a_req}, {31'b0, vecs[i].ereq});
      check($sformatf("v%0d_addr", i), a_addr, vecs[i].eaddr);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), {31'b0, a_valid}, {31'b0, vecs[i].evalid});
      check($sformatf("v%0d_pc", i), a_pc, vecs[i].epc);
      check($sformatf("v%0d_instr", i), a_instr, vecs[i].einstr);
      check($sformatf("v%0d_op", i), {25'b0, a_op}, {25'b0, vecs[i].einstr[6:0]});
    end
    @(negedge clk);
    a_start = 0; a_stall = 0; a_flush = 0; a_ack_en = 0;

    // PC wrap on DUT B.
    check("b_idle_req", {31'b0, b_req}, 32'h0);
    b_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_start = 1'b0;
    #1;
    check("b_req", {31'b0, b_req}, 32'h1);
    check("b_addr0", b_addr, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("b_valid0", {31'b0, b_valid}, 32'h1);
    check("b_pc0", b_pc, 32'hFFFF_FFF8);
    check("b_instr0", b_instr, 32'h5A5A_FFF8);
    @(negedge clk); #1;
    check("b_addr1", b_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("b_pc1", b_pc, 32'hFFFF_FFFC);
    check("b_instr1", b_instr, 32'h5A5A_FFFC);
    @(negedge clk); #1;
    check("b_addr_wrap", b_addr, 32'h0000_0000);

    // Asynchronous reset between clock edges.
    #1 rst_n = 1'b0;
    #1;
    check("arst_b_req", {31'b0, b_req}, 32'h0);
    check("arst_b_addr", b_addr, 32'hFFFF_FFF8);
    check("arst_b_valid", {31'b0, b_valid}, 32'h0);
    check("arst_b_pc", b_pc, 32'h0);
    check("arst_b_instr", b_instr, NOP);
    check("arst_b_op", {25'b0, b_op}, 32'h13);
    check("arst_a_req", {31'b0, a_req}, 32'h0);
    check("arst_a_addr", a_addr, 32'h0);
    check("arst_a_valid", {31'b0, a_valid}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage: the producer of the 7-bit opcode and instruction word consumed by the decode/Control logic.
- Owns the PC.
- Issues one-outstanding req/ack reads to instruction memory.
- Drives the IF/ID pipeline register, including stall hold, branch redirect/flush, and a one-entry skid buffer for data returned during a stall.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when invalid

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  begin fetching; sampled only in IDLE
imem_req_o  out  1  read request to instruction memory
imem_addr_o  out  32  read address; equals current PC
imem_ack_i  in  1  read complete; may be combinational from req (zero-wait)
imem_data_i  in  32  instruction word, valid only when imem_ack_i=1
stall_i  in  1  hold IF/ID and PC (load-use hazard)
flush_i  in  1  taken branch/redirect from ID
branch_target_i  in  32  redirect PC; bits [1:0] forced to 0
ifid_valid_o  out  1  IF/ID holds a real instruction
ifid_pc_o  out  32  PC of the IF/ID instruction
ifid_instr_o  out  32  IF/ID instruction word
ifid_op_o  out  7  ifid_instr_o[6:0], the opcode driven to Control

Behaviour:
- Reset (async, rst_i=0):
  - pc=PC_RESET, state=IDLE, imem_req_o=0, imem_addr_o=PC_RESET.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_op_o=7'b0010011, skid buffer empty.
- Priority each cycle: flush_i > stall_i > imem_ack_i.
- Handshake:
  - imem_req_o and imem_addr_o stay stable from assertion until the cycle imem_ack_i=1.
  - At most one request is outstanding.
  - imem_req_o is asserted only in REQ and DROP.
- FSM states: IDLE, REQ, HOLD, DROP.
  - IDLE: req=0. start_i=1 -> REQ next cycle. flush_i updates pc and stays IDLE.
  - REQ: req=1, addr=pc.
    - ack & !stall & !flush: IF/ID <= {1, pc, data}; pc <= pc+4; remain REQ. Gives 1 instr/cycle with zero-wait memory.
    - !ack & !stall & !flush: IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc unchanged); remain REQ.
    - ack & stall & !flush: IF/ID held; data and pc go to the skid buffer; pc <= pc+4; -> HOLD.
    - !ack & stall: IF/ID held; remain REQ.
    - flush & ack: data discarded; pc <= target; IF/ID <= bubble; remain REQ with the new address next cycle.
    - flush & !ack: pc <= target; IF/ID <= bubble; -> DROP.
  - HOLD: req=0.
    - stall_i=0: IF/ID <= skid buffer (valid=1); -> REQ.
    - flush_i: buffer discarded; pc <= target; IF/ID <= bubble; -> REQ.
  - DROP: req=1 with the stale address, held until ack.
    - On ack: data discarded; -> REQ using the redirected pc.
    - A further flush in DROP overwrites pc and stays in DROP.
    - IF/ID is bubble throughout.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - pc[1:0] is always 0.
- Reset mid-request: the request is abandoned immediately. The memory is required to tolerate req dropping.
- ifid_op_o is combinationally ifid_instr_o[6:0]. All other outputs are registered, except imem_req_o/imem_addr_o, which are decoded from state and pc.

Decomposition:
- Shared package fetch_pkg:
  - FSM state enum.
  - NOP_INSTR.
  - Opcode constants OP_RTYPE 7'b0110011, OP_ITYPE 7'b0010011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011.
  - PC_STEP=4.
- One sub-module, fetch_ifid_reg: IF/ID register with load/hold/bubble select and the skid buffer. The FSM and PC stay in fetch_unit.

Test Plan:
1. Reset, start_i pulse, zero-wait memory returning addr^32'hA5A5_0000 -> imem_addr_o 0,4,8,... on consecutive cycles; ifid_valid_o=1 from the 2nd cycle after start; ifid_pc_o tracks addr one cycle late.
2. Memory acks with 2-cycle latency -> imem_addr_o held stable through the wait; bubbles with ifid_instr_o=32'h0000_0013 and valid=0 between instructions.
3. stall_i high 3 cycles coincident with ack of PC=0x10 -> IF/ID holds the PC=0x0C instruction; no req during HOLD; after release, ifid_pc_o=0x10 with the correct data, then a fetch at 0x14.
4. flush_i with branch_target_i=32'h0000_0103 while a request to 0x20 is pending (no ack) -> DROP until ack, that data discarded, next request at 0x100, IF/ID bubble meanwhile.
5. flush_i and stall_i asserted together with ack -> flush wins: IF/ID bubble, pc=target, skid buffer empty.
6. PC_RESET=32'hFFFF_FFF8, zero-wait memory -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; async reset asserted mid-stream -> all outputs return to reset values with no clock edge.
